// File: rtl/pattern_pulse_gen_if.sv
// Bundle of configuration, control and pulse-output signals for pattern_pulse_gen.
// The master drives configuration and start/stop; the slave returns per-channel outputs.
interface pattern_pulse_gen_if #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 2
);
   localparam int LW = $clog2(WIDTH) + 1;
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic                load;
   logic [CW-1:0]       ch_sel;
   logic [WIDTH-1:0]    Q_in;
   logic [LW-1:0]       len;
   logic                mode;
   logic [CHANNELS-1:0] start;
   logic [CHANNELS-1:0] stop;
   logic [CHANNELS-1:0] Q_out;
   logic [CHANNELS-1:0] busy;
   logic [CHANNELS-1:0] done;

   modport master (
      output load, ch_sel, Q_in, len, mode, start, stop,
      input  Q_out, busy, done
   );

   modport slave (
      input  load, ch_sel, Q_in, len, mode, start, stop,
      output Q_out, busy, done
   );
endinterface

// File: rtl/pattern_pulse_gen.sv
// Multi-channel serial pattern generator: each channel shifts out a stored pattern MSB
// first, either repeating forever or once with a done pulse on the last bit.
module pattern_pulse_gen #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 2
) (
   input logic                CLK,
   input logic                RSTn,
   pattern_pulse_gen_if.slave bus
);
   localparam int LW = $clog2(WIDTH) + 1;
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   state_e              state_q [CHANNELS];
   state_e              state_d [CHANNELS];
   logic [LW-1:0]       idx_q   [CHANNELS];
   logic [LW-1:0]       idx_d   [CHANNELS];
   logic [LW-1:0]       len_q   [CHANNELS];
   logic [LW-1:0]       len_d   [CHANNELS];
   logic [WIDTH-1:0]    pat_q   [CHANNELS];
   logic [WIDTH-1:0]    pat_d   [CHANNELS];
   logic                mode_q  [CHANNELS];
   logic                mode_d  [CHANNELS];

   logic [CHANNELS-1:0] q_out_q, q_out_d;
   logic [CHANNELS-1:0] busy_q,  busy_d;
   logic [CHANNELS-1:0] done_q,  done_d;
   logic [LW-1:0]       len_eff;

   // A zero or oversized length selects the full pattern width.
   assign len_eff = ((bus.len == '0) || (bus.len > LW'(WIDTH))) ? LW'(WIDTH) : bus.len;

   // NOTE: the per-channel config arrays are small flop banks, not RAM, so they take an async reset.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int c = 0; c < CHANNELS; c++) begin
            state_q[c] <= IDLE;
            idx_q[c]   <= '0;
            len_q[c]   <= LW'(WIDTH);
            pat_q[c]   <= '0;
            mode_q[c]  <= 1'b0;
         end
         q_out_q <= '0;
         busy_q  <= '0;
         done_q  <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of its inputs.
         for (int c = 0; c < CHANNELS; c++) begin
            state_q[c] <= state_d[c];
            idx_q[c]   <= idx_d[c];
            len_q[c]   <= len_d[c];
            pat_q[c]   <= pat_d[c];
            mode_q[c]  <= mode_d[c];
         end
         q_out_q <= q_out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         // NOTE: hold-by-default assignments keep this block free of inferred latches.
         state_d[c] = state_q[c];
         idx_d[c]   = idx_q[c];
         len_d[c]   = len_q[c];
         pat_d[c]   = pat_q[c];
         mode_d[c]  = mode_q[c];

         if (bus.load && (bus.ch_sel == CW'(c))) begin
            pat_d[c]   = bus.Q_in;
            len_d[c]   = len_eff;
            mode_d[c]  = bus.mode;
            state_d[c] = IDLE;
            idx_d[c]   = '0;
         end else begin
            unique case (state_q[c])
               IDLE: begin
                  if (bus.start[c]) begin
                     state_d[c] = RUN;
                     idx_d[c]   = '0;
                  end
               end
               RUN: begin
                  if (bus.stop[c]) begin
                     state_d[c] = IDLE;
                     idx_d[c]   = '0;
                  end else if (idx_q[c] == (len_q[c] - LW'(1))) begin
                     idx_d[c] = '0;
                     if (mode_q[c]) state_d[c] = IDLE;
                  end else begin
                     idx_d[c] = idx_q[c] + LW'(1);
                  end
               end
               default: state_d[c] = IDLE;
            endcase
         end
      end
   end

   // Outputs are decoded from next state so the registered copies line up with the state.
   always_comb begin
      logic [WIDTH-1:0] shifted;
      shifted = '0;
      q_out_d = '0;
      busy_d  = '0;
      done_d  = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         shifted = pat_d[c] << idx_d[c];
         if (state_d[c] == RUN) begin
            q_out_d[c] = shifted[WIDTH-1];
            busy_d[c]  = 1'b1;
            done_d[c]  = mode_d[c] && (idx_d[c] == (len_d[c] - LW'(1)));
         end
      end
   end

   assign bus.Q_out = q_out_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
endmodule

// File: tb/tb_pattern_pulse_gen.sv
// Scoreboard bench for pattern_pulse_gen (WIDTH=16, CHANNELS=2): a behavioural channel
// model predicts each cycle's outputs, which are queued and compared on the falling edge.
module tb_pattern_pulse_gen;
   localparam int WIDTH    = 16;
   localparam int CHANNELS = 2;

   typedef struct packed {
      logic [1:0] q;
      logic [1:0] busy;
      logic [1:0] done;
   } exp_t;

   logic clk;
   logic rst_n;

   pattern_pulse_gen_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

   pattern_pulse_gen #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
      .CLK  (clk),
      .RSTn (rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t  sb_q [$];
   int    n_checks = 0;
   int    n_errors = 0;
   string cur_test = "reset";

   logic [15:0] m_pat [2];
   int          m_len [2];
   bit          m_one [2];
   bit          m_run [2];
   int          m_pos [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s.%s: got %0h expected %0h at %0t", cur_test, tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_pat[c] = '0;
         m_len[c] = 16;
         m_one[c] = 1'b0;
         m_run[c] = 1'b0;
         m_pos[c] = 0;
      end
   endtask

   function automatic exp_t model_out();
      exp_t        e;
      logic [15:0] tmp;
      e = '0;
      for (int c = 0; c < 2; c++) begin
         if (m_run[c]) begin
            tmp       = m_pat[c] << m_pos[c];
            e.q[c]    = tmp[15];
            e.busy[c] = 1'b1;
            e.done[c] = m_one[c] && (m_pos[c] == m_len[c] - 1);
         end
      end
      return e;
   endfunction

   task automatic model_step(input bit ld, input int sel, input logic [15:0] qin, input int ln,
                             input bit md, input logic [1:0] st, input logic [1:0] sp);
      for (int c = 0; c < 2; c++) begin
         if (ld && sel == c) begin
            m_pat[c] = qin;
            m_len[c] = (ln == 0 || ln > 16) ? 16 : ln;
            m_one[c] = md;
            m_run[c] = 1'b0;
            m_pos[c] = 0;
         end else if (m_run[c]) begin
            if (sp[c]) begin
               m_run[c] = 1'b0;
               m_pos[c] = 0;
            end else if (m_pos[c] + 1 >= m_len[c]) begin
               m_pos[c] = 0;
               if (m_one[c]) m_run[c] = 1'b0;
            end else begin
               m_pos[c]++;
            end
         end else if (st[c]) begin
            m_run[c] = 1'b1;
            m_pos[c] = 0;
         end
      end
   endtask

   // Drive one cycle of stimulus from the falling edge, then compare at the next falling edge.
   task automatic tick(input bit ld, input int sel, input logic [15:0] qin, input int ln,
                       input bit md, input logic [1:0] st, input logic [1:0] sp);
      exp_t e;
      bus.load   = ld;
      bus.ch_sel = 1'(sel);
      bus.Q_in   = qin;
      bus.len    = 5'(ln);
      bus.mode   = md;
      bus.start  = st;
      bus.stop   = sp;
      model_step(ld, sel, qin, ln, md, st, sp);
      sb_q.push_back(model_out());
      @(posedge clk);
      @(negedge clk);
      e = sb_q.pop_front();
      check("q_out", 32'(bus.Q_out), 32'(e.q));
      check("busy",  32'(bus.busy),  32'(e.busy));
      check("done",  32'(bus.done),  32'(e.done));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 0, 16'h0, 0, 1'b0, 2'b00, 2'b00);
   endtask

   task automatic load_ch(input int sel, input logic [15:0] qin, input int ln, input bit md);
      tick(1'b1, sel, qin, ln, md, 2'b00, 2'b00);
   endtask

   task automatic start_ch(input logic [1:0] st);
      tick(1'b0, 0, 16'h0, 0, 1'b0, st, 2'b00);
   endtask

   initial begin
      rst_n      = 1'b0;
      bus.load   = 1'b0;
      bus.ch_sel = '0;
      bus.Q_in   = '0;
      bus.len    = '0;
      bus.mode   = 1'b0;
      bus.start  = '0;
      bus.stop   = '0;
      model_reset();

      repeat (2) @(negedge clk);
      check("rst_q_out", 32'(bus.Q_out), 32'h0);
      check("rst_busy",  32'(bus.busy),  32'h0);
      check("rst_done",  32'(bus.done),  32'h0);
      rst_n = 1'b1;

      cur_test = "post_reset";
      idle(2);
      tick(1'b0, 0, 16'h0, 0, 1'b0, 2'b00, 2'b11);
      start_ch(2'b01);
      idle(18);
      tick(1'b0, 0, 16'h0, 0, 1'b0, 2'b00, 2'b01);
      idle(1);

      cur_test = "repeat_aaaa";
      load_ch(0, 16'hAAAA, 0, 1'b0);
      start_ch(2'b01);
      idle(20);

      cur_test = "load_other_ch";
      load_ch(1, 16'hFFFF, 0, 1'b1);
      idle(4);
      start_ch(2'b11);
      idle(18);
      tick(1'b0, 0, 16'h0, 0, 1'b0, 2'b11, 2'b01);
      idle(1);

      cur_test = "oneshot_e000";
      load_ch(0, 16'hE000, 16, 1'b1);
      start_ch(2'b01);
      idle(17);
      cur_test = "oneshot_restart";
      start_ch(2'b01);
      idle(17);

      cur_test = "repeat_c000_len3";
      load_ch(1, 16'hC000, 3, 1'b0);
      start_ch(2'b10);
      idle(7);
      tick(1'b0, 0, 16'h0, 0, 1'b0, 2'b00, 2'b10);
      idle(2);

      cur_test = "load_start_same_edge";
      tick(1'b1, 0, 16'h8001, 4, 1'b1, 2'b01, 2'b00);
      idle(2);
      start_ch(2'b01);
      idle(5);

      cur_test = "start_ignored_in_run";
      load_ch(1, 16'hF0F0, 20, 1'b0);
      start_ch(2'b10);
      for (int i = 0; i < 20; i++) tick(1'b0, 0, 16'h0, 0, 1'b0, 2'b10, 2'b00);
      tick(1'b0, 0, 16'h0, 0, 1'b0, 2'b10, 2'b10);
      idle(1);

      cur_test = "oneshot_len1";
      load_ch(0, 16'h8000, 1, 1'b1);
      start_ch(2'b01);
      idle(2);

      cur_test = "async_reset";
      load_ch(0, 16'hAAAA, 0, 1'b0);
      load_ch(1, 16'hC000, 3, 1'b0);
      start_ch(2'b11);
      idle(5);
      #2 rst_n = 1'b0;
      #1;
      check("arst_q_out", 32'(bus.Q_out), 32'h0);
      check("arst_busy",  32'(bus.busy),  32'h0);
      check("arst_done",  32'(bus.done),  32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cur_test = "after_async_reset";
      idle(3);
      start_ch(2'b10);
      idle(17);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
